// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants used by the fetch-stage branch target buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Weakly-taken direction counter value: MSB set, all other bits clear (10...0).
  function automatic logic [31:0] btb_ctr_weak_taken(input int w);
    return 32'd1 << (w - 1);
  endfunction

  // Weakly-not-taken direction counter value: MSB clear, all other bits set (01...1).
  // For a 1-bit counter this degenerates to 0.
  function automatic logic [31:0] btb_ctr_weak_ntaken(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// 32-bit saturating event counter; increments once per cycle while en is high.
// Latency: the count reflects an enabled cycle on the following clock edge.
// Backpressure: none; the count holds at 32'hFFFF_FFFF instead of wrapping.
//
// Ports: CLK, nRST (async active-low) | en: count this cycle | count: current value.
module perf_counter
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  output word_t count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counters, misprediction detect and perf counters.
// Latency: lookup is combinational; an update becomes visible to lookups the cycle after its clock edge.
// Backpressure: none; the datapath holds lk_pc and pulses upd_en once per resolved instruction.
//
// Ports: CLK, nRST (async active-low), clr (sync invalidate of all entries)
//        lk_pc -> lk_hit / lk_taken / lk_target            (IF stage lookup)
//        upd_* -> mispredict / recover_pc, entry write     (EX stage resolution)
//        branch_count / mispredict_count                   (saturating performance counters)
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        clr,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_uncond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] recover_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  localparam logic [CTR_W-1:0] CTR_ONES    = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(btb_ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(btb_ctr_weak_ntaken(CTR_W));
  localparam btb_entry_t       ENTRY_RST   = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};

  btb_entry_t mem [ENTRIES];

  // Byte offset bits of word-aligned PCs carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  // ---------------- Lookup ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_e;

  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[31:IDX_W+2];
  assign lk_e      = mem[lk_idx];
  assign lk_hit    = lk_e.valid && (lk_e.tag == lk_tag);
  assign lk_taken  = lk_hit && lk_e.ctr[CTR_W-1];
  assign lk_target = lk_taken ? lk_e.target : lk_pc + 32'd4;

  // ---------------- Update ----------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       upd_e;
  btb_entry_t       new_e;
  logic             upd_hit;
  logic             upd_wr;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  always_comb begin
    upd_e   = mem[upd_idx];
    upd_hit = upd_e.valid && (upd_e.tag == upd_tag);
    new_e   = upd_e;
    upd_wr  = 1'b0;
    if (upd_hit) begin
      upd_wr = 1'b1;
      if (upd_uncond) begin
        new_e.ctr = CTR_ONES;
      end else if (upd_taken) begin
        if (upd_e.ctr != CTR_ONES) new_e.ctr = upd_e.ctr + CTR_W'(1);
      end else begin
        if (upd_e.ctr != '0) new_e.ctr = upd_e.ctr - CTR_W'(1);
      end
      if (upd_taken) new_e.target = upd_target;
    end else if (upd_taken) begin
      // Allocate, evicting whatever aliases to this index.
      upd_wr       = 1'b1;
      new_e.valid  = 1'b1;
      new_e.tag    = upd_tag;
      new_e.target = upd_target;
      new_e.ctr    = upd_uncond ? CTR_ONES : CTR_WEAK_T;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= ENTRY_RST;
    end else if (clr) begin
      // clr takes priority over any same-cycle update.
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (upd_en && upd_wr) begin
      mem[upd_idx] <= new_e;
    end
  end

  // ---------------- Misprediction / recovery ----------------
  assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));
  assign recover_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  // Performance counters count every resolved update, even when clr drops the entry write.
  perf_counter u_branch_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (upd_en),
    .count (branch_count)
  );

  perf_counter u_mispredict_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16, CTR_W=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_target_buffer;

  logic        CLK;
  logic        nRST;
  logic        clr;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_uncond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int tests_run;
  int tests_failed;

  branch_target_buffer #(.ENTRIES(16), .CTR_W(2)) u_dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .clr              (clr),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_taken         (lk_taken),
    .lk_target        (lk_target),
    .upd_en           (upd_en),
    .upd_pc           (upd_pc),
    .upd_uncond       (upd_uncond),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .recover_pc       (recover_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one resolved instruction on the update port (held until step()).
  task automatic upd(input logic [31:0] pc, input logic uncond, input logic taken,
                     input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    upd_en          = 1'b1;
    upd_pc          = pc;
    upd_uncond      = uncond;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptgt;
  endtask

  // Advance one clock; inputs are released again on the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    upd_en = 1'b0;
    clr    = 1'b0;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    lk_pc = pc;
    #1;
    check({tag, ".hit"},    {31'd0, lk_hit},   {31'd0, hit});
    check({tag, ".taken"},  {31'd0, lk_taken}, {31'd0, taken});
    check({tag, ".target"}, lk_target,         tgt);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    nRST            = 1'b0;
    clr             = 1'b0;
    lk_pc           = 32'h40;
    upd_en          = 1'b0;
    upd_pc          = '0;
    upd_uncond      = 1'b0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    #1;

    // Reset state
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    check("rst.bc",   branch_count, 32'd0);
    check("rst.mc",   mispredict_count, 32'd0);
    check("rst.misp", {31'd0, mispredict}, 32'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // First install at 0x40 (weakly taken), mispredicted
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    check("inst.misp", {31'd0, mispredict}, 32'd1);
    check("inst.rpc",  recover_pc, 32'h80);
    step();
    look("inst", 32'h40, 1'b1, 1'b1, 32'h80);
    check("inst.mc", mispredict_count, 32'd1);

    // Three not-taken updates: 10 -> 01 -> 00 -> 00
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    check("nt1.misp", {31'd0, mispredict}, 32'd1);
    check("nt1.rpc",  recover_pc, 32'h44);
    step();
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    #1;
    check("nt2.misp", {31'd0, mispredict}, 32'd0);
    step();
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    step();
    look("nt3", 32'h40, 1'b1, 1'b0, 32'h44);
    // One taken from a saturated 00 -> 01, still predicted not taken
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    step();
    look("sat0", 32'h40, 1'b1, 1'b0, 32'h44);
    check("sat0.bc", branch_count, 32'd5);
    check("sat0.mc", mispredict_count, 32'd3);

    // Alias: 0x80 shares index 0 with 0x40 and evicts it
    upd(32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84);
    step();
    look("alias40", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias80", 32'h80, 1'b1, 1'b1, 32'h200);

    // Unconditional install gives 11; one not-taken leaves it taken (10)
    upd(32'h44, 1'b1, 1'b1, 32'h300, 1'b0, 32'h48);
    step();
    upd(32'h44, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    check("unc.rpc", recover_pc, 32'h48);
    step();
    look("unc", 32'h44, 1'b1, 1'b1, 32'h300);
    check("unc.bc", branch_count, 32'd8);
    check("unc.mc", mispredict_count, 32'd6);

    // Same-cycle lookup and first install of 0x100: lookup sees old contents
    upd(32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 32'h104);
    look("same0", 32'h100, 1'b0, 1'b0, 32'h104);
    step();
    look("same1", 32'h100, 1'b1, 1'b1, 32'h180);

    // clr with upd_en: no install, everything invalidated, counters still count
    upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b1, 32'h400);
    clr = 1'b1;
    step();
    look("clr48",  32'h48,  1'b0, 1'b0, 32'h4C);
    look("clr100", 32'h100, 1'b0, 1'b0, 32'h104);
    check("clr.bc", branch_count, 32'd10);
    check("clr.mc", mispredict_count, 32'd7);

    // Reinstall, then an asynchronous reset pulse mid-stream with an update pending
    upd(32'h100, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
    step();
    look("reinst", 32'h100, 1'b1, 1'b1, 32'h180);
    upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b0, 32'h4C);
    nRST = 1'b0;
    #1;
    look("arst100", 32'h100, 1'b0, 1'b0, 32'h104);
    check("arst.bc", branch_count, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    upd_en = 1'b0;
    nRST   = 1'b1;
    #1;
    look("arst48", 32'h48, 1'b0, 1'b0, 32'h4C);
    check("arst.bc2", branch_count, 32'd0);

    // Saturation of branch_count
    force u_dut.u_branch_cnt.count = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_branch_cnt.count;
    upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    #1;
    check("sat.rpc", recover_pc, 32'h0);
    step();
    check("sat.bc", branch_count, 32'hFFFF_FFFF);
    check("sat.mc", mispredict_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
